// File: rtl/store_fwd_buf_pkg.sv
// Shared defaults, the speculation-level type and the branch-promotion table lookup.
package store_fwd_buf_pkg;
  localparam int INST_ID_BIT_DEF    = 8;
  localparam int ADDR_BIT_DEF       = 16;
  localparam int DATA_BIT_DEF       = 16;
  localparam int BUF_DEPTH_DEF      = 16;
  localparam int SPEC_DEPTH_DEF     = 4;
  localparam int SPEC_LEVEL_BIT_DEF = $clog2(SPEC_DEPTH_DEF) + 1;
  localparam int LVL_VEC_MAX        = 64;
  localparam int LVL_SLICE_MAX      = 32;

  typedef logic [SPEC_LEVEL_BIT_DEF-1:0] spec_level_t;

  // Slice `lvl` of the packed next-level table; levels past the table keep their value.
  function automatic logic [7:0] succ_level_lookup(
    input logic [LVL_VEC_MAX-1:0] tbl,
    input logic [7:0]             lvl,
    input int                     lvl_bit,
    input int                     n_slice
  );
    logic [LVL_VEC_MAX-1:0] mask;
    logic [7:0]             res;
    mask = (LVL_VEC_MAX'(1) << lvl_bit) - LVL_VEC_MAX'(1);
    res  = lvl;
    for (int s = 0; s < LVL_SLICE_MAX; s++) begin
      if (s < n_slice && lvl == 8'(s)) res = 8'((tbl >> (s * lvl_bit)) & mask);
    end
    return res;
  endfunction
endpackage

// File: rtl/store_fwd_buf_if.sv
// Enqueue, commit, branch-resolution and load-forwarding signals of the store buffer.
interface store_fwd_buf_if #(
  parameter int INST_ID_BIT    = 8,
  parameter int ADDR_BIT       = 16,
  parameter int DATA_BIT       = 16,
  parameter int BUF_DEPTH      = 16,
  parameter int SPEC_DEPTH     = 4,
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  parameter int PTR_BIT        = $clog2(BUF_DEPTH)
);
  logic                                    in_vld;
  logic                                    in_rdy;
  logic [INST_ID_BIT-1:0]                  in_id;
  logic [ADDR_BIT-1:0]                     in_addr;
  logic [DATA_BIT-1:0]                     in_data;
  logic [SPEC_LEVEL_BIT-1:0]               in_spec_level;
  logic                                    out_vld;
  logic                                    out_rdy;
  logic [INST_ID_BIT-1:0]                  out_id;
  logic [ADDR_BIT-1:0]                     out_addr;
  logic [DATA_BIT-1:0]                     out_data;
  logic                                    empty;
  logic [PTR_BIT:0]                        count;
  logic                                    br_pred_vld;
  logic                                    br_pred_succ;
  logic [SPEC_LEVEL_BIT-1:0]               br_pred_fail_level;
  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels;
  logic                                    ld_vld;
  logic [ADDR_BIT-1:0]                     ld_addr;
  logic                                    ld_hit;
  logic [DATA_BIT-1:0]                     ld_data;
  logic [INST_ID_BIT-1:0]                  ld_id;

  modport master (
    output in_vld, in_id, in_addr, in_data, in_spec_level, out_rdy,
           br_pred_vld, br_pred_succ, br_pred_fail_level, br_pred_succ_nxt_levels,
           ld_vld, ld_addr,
    input  in_rdy, out_vld, out_id, out_addr, out_data, empty, count,
           ld_hit, ld_data, ld_id
  );

  modport slave (
    input  in_vld, in_id, in_addr, in_data, in_spec_level, out_rdy,
           br_pred_vld, br_pred_succ, br_pred_fail_level, br_pred_succ_nxt_levels,
           ld_vld, ld_addr,
    output in_rdy, out_vld, out_id, out_addr, out_data, empty, count,
           ld_hit, ld_data, ld_id
  );
endinterface

// File: rtl/store_fwd_buf_match_sel.sv
// Youngest-match selector: scans from wptr-1 back around the ring, first hit wins.
module sfb_match_sel #(
  parameter int BUF_DEPTH = 16,
  parameter int PTR_BIT   = $clog2(BUF_DEPTH)
) (
  input  logic [BUF_DEPTH-1:0] cmp_i,
  input  logic [PTR_BIT-1:0]   wptr_i,
  output logic                 hit_o,
  output logic [PTR_BIT-1:0]   sel_o
);
  logic [PTR_BIT-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int k = BUF_DEPTH; k >= 1; k--) begin
      idx = wptr_i - PTR_BIT'(k);
      if (cmp_i[idx]) begin
        hit_o = 1'b1;
        sel_o = idx;
      end
    end
  end
endmodule

// File: rtl/store_fwd_buf.sv
// Speculative store buffer: in-order commit of non-speculative stores, branch squash/promotion, load forwarding.
module store_fwd_buf
  import store_fwd_buf_pkg::*;
#(
  parameter int INST_ID_BIT    = INST_ID_BIT_DEF,
  parameter int ADDR_BIT       = ADDR_BIT_DEF,
  parameter int DATA_BIT       = DATA_BIT_DEF,
  parameter int BUF_DEPTH      = BUF_DEPTH_DEF,
  parameter int SPEC_DEPTH     = SPEC_DEPTH_DEF,
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  parameter int PTR_BIT        = $clog2(BUF_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  store_fwd_buf_if.slave bus
);
  logic [BUF_DEPTH-1:0]      vld_q, vld_d;
  logic [SPEC_LEVEL_BIT-1:0] lvl_q  [BUF_DEPTH];
  logic [SPEC_LEVEL_BIT-1:0] lvl_d  [BUF_DEPTH];
  logic [INST_ID_BIT-1:0]    id_q   [BUF_DEPTH];
  logic [ADDR_BIT-1:0]       addr_q [BUF_DEPTH];
  logic [DATA_BIT-1:0]       data_q [BUF_DEPTH];
  logic [PTR_BIT-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_BIT:0]          count_q, count_d;
  logic                      enq, commit, skip, deq, head_vld;
  logic [BUF_DEPTH-1:0]      ld_cmp;
  logic                      ld_any;
  logic [PTR_BIT-1:0]        ld_sel;
  logic [LVL_VEC_MAX-1:0]    lvl_tbl;

  assign head_vld     = vld_q[rptr_q];
  assign bus.in_rdy   = int'(count_q) < BUF_DEPTH;
  assign bus.out_vld  = head_vld && (lvl_q[rptr_q] == '0);
  assign bus.out_id   = id_q[rptr_q];
  assign bus.out_addr = addr_q[rptr_q];
  assign bus.out_data = data_q[rptr_q];
  assign bus.empty    = ~|vld_q;
  assign bus.count    = count_q;

  assign enq     = bus.in_vld && bus.in_rdy;
  assign commit  = bus.out_vld && bus.out_rdy;
  // Squashed slots are reclaimed here, one per cycle, once they reach the head.
  assign skip    = !head_vld && (count_q != '0);
  assign deq     = commit || skip;
  assign lvl_tbl = LVL_VEC_MAX'(bus.br_pred_succ_nxt_levels);

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      lvl_d[i] = lvl_q[i];
      if (bus.br_pred_vld) begin
        if (bus.br_pred_succ) begin
          if (vld_q[i]) begin
            lvl_d[i] = SPEC_LEVEL_BIT'(succ_level_lookup(lvl_tbl, 8'(lvl_q[i]),
                                                         SPEC_LEVEL_BIT, SPEC_DEPTH + 1));
          end
        end else if (lvl_q[i] >= bus.br_pred_fail_level) begin
          vld_d[i] = 1'b0;
        end
      end
      if (commit && PTR_BIT'(i) == rptr_q) vld_d[i] = 1'b0;
      if (enq && PTR_BIT'(i) == wptr_q) begin
        vld_d[i] = 1'b1;
        lvl_d[i] = bus.in_spec_level;
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) wptr_d = wptr_q + PTR_BIT'(1);
    if (deq) rptr_d = rptr_q + PTR_BIT'(1);
    if (enq && !deq)      count_d = count_q + (PTR_BIT+1)'(1);
    else if (!enq && deq) count_d = count_q - (PTR_BIT+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) lvl_q <= lvl_d;
    if (!rst && enq) begin
      id_q[wptr_q]   <= bus.in_id;
      addr_q[wptr_q] <= bus.in_addr;
      data_q[wptr_q] <= bus.in_data;
    end
  end

  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) ld_cmp[i] = vld_q[i] && (addr_q[i] == bus.ld_addr);
  end

  sfb_match_sel #(
    .BUF_DEPTH (BUF_DEPTH),
    .PTR_BIT   (PTR_BIT)
  ) u_match_sel (
    .cmp_i  (ld_cmp),
    .wptr_i (wptr_q),
    .hit_o  (ld_any),
    .sel_o  (ld_sel)
  );

  assign bus.ld_hit  = bus.ld_vld && ld_any;
  assign bus.ld_data = bus.ld_hit ? data_q[ld_sel] : '0;
  assign bus.ld_id   = bus.ld_hit ? id_q[ld_sel] : '0;
endmodule

// File: tb/tb_store_fwd_buf.sv
// Store buffer bench: directed scenarios plus random traffic against an ordered-queue reference model.
module tb_store_fwd_buf;
  import store_fwd_buf_pkg::*;

  localparam int SLB = SPEC_LEVEL_BIT_DEF;

  typedef struct {
    logic        vld;
    logic [7:0]  id;
    logic [15:0] addr;
    logic [15:0] data;
    spec_level_t lvl;
  } ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  ent_t mq[$];

  store_fwd_buf_if bus ();

  store_fwd_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference: the occupied slots as an ordered list, oldest first.
  task automatic model_step();
    int          n;
    logic        e_head, e_enq, e_pop, e_empty, e_hit;
    logic [15:0] e_ld_data;
    logic [7:0]  e_ld_id;
    logic [SLB*(SPEC_DEPTH_DEF+1)-1:0] nl;
    ent_t        ne;
    n      = mq.size();
    e_head = (n > 0) && mq[0].vld && (mq[0].lvl == 0);
    chk("in_rdy", 32'(bus.in_rdy), 32'(n < BUF_DEPTH_DEF));
    chk("out_vld", 32'(bus.out_vld), 32'(e_head));
    if (e_head) begin
      chk("out_id", 32'(bus.out_id), 32'(mq[0].id));
      chk("out_addr", 32'(bus.out_addr), 32'(mq[0].addr));
      chk("out_data", 32'(bus.out_data), 32'(mq[0].data));
    end
    e_empty = 1'b1;
    for (int k = 0; k < n; k++) if (mq[k].vld) e_empty = 1'b0;
    chk("empty", 32'(bus.empty), 32'(e_empty));
    chk("count", 32'(bus.count), 32'(n));
    e_hit = 1'b0; e_ld_data = '0; e_ld_id = '0;
    if (bus.ld_vld) begin
      for (int k = n - 1; k >= 0; k--) begin
        if (!e_hit && mq[k].vld && mq[k].addr == bus.ld_addr) begin
          e_hit = 1'b1; e_ld_data = mq[k].data; e_ld_id = mq[k].id;
        end
      end
    end
    chk("ld_hit", 32'(bus.ld_hit), 32'(e_hit));
    chk("ld_data", 32'(bus.ld_data), 32'(e_ld_data));
    chk("ld_id", 32'(bus.ld_id), 32'(e_ld_id));
    if (rst) begin
      mq.delete();
    end else begin
      e_enq = bus.in_vld && (n < BUF_DEPTH_DEF);
      e_pop = (e_head && bus.out_rdy) || (n > 0 && !mq[0].vld);
      if (e_pop) void'(mq.pop_front());
      if (bus.br_pred_vld) begin
        nl = bus.br_pred_succ_nxt_levels;
        for (int k = 0; k < mq.size(); k++) begin
          if (bus.br_pred_succ) begin
            if (mq[k].vld) mq[k].lvl = spec_level_t'(nl >> (SLB * int'(mq[k].lvl)));
          end else if (mq[k].lvl >= bus.br_pred_fail_level) begin
            mq[k].vld = 1'b0;
          end
        end
      end
      if (e_enq) begin
        ne.vld = 1'b1; ne.id = bus.in_id; ne.addr = bus.in_addr;
        ne.data = bus.in_data; ne.lvl = bus.in_spec_level;
        mq.push_back(ne);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.in_vld = 1'b0; bus.in_id = '0; bus.in_addr = '0; bus.in_data = '0;
    bus.in_spec_level = '0; bus.out_rdy = 1'b0;
    bus.br_pred_vld = 1'b0; bus.br_pred_succ = 1'b0; bus.br_pred_fail_level = '0;
    bus.br_pred_succ_nxt_levels = '0; bus.ld_vld = 1'b0; bus.ld_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] id, input logic [15:0] addr,
                      input logic [15:0] data, input spec_level_t lvl);
    bus.in_vld = 1'b1; bus.in_id = id; bus.in_addr = addr;
    bus.in_data = data; bus.in_spec_level = lvl;
    cycle();
    bus.in_vld = 1'b0;
  endtask

  initial begin
    int          ncommit;
    logic [7:0]  cid;
    logic [SLB*(SPEC_DEPTH_DEF+1)-1:0] nl;
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();

    // Post-reset outputs
    bus.ld_vld = 1'b1; bus.ld_addr = 16'h0010;
    #1;
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
    chk("rst_ld_data", 32'(bus.ld_data), 32'd0);
    chk("rst_ld_id", 32'(bus.ld_id), 32'd0);

    // Fill to full, then drain in order; full buffer refuses a store even while draining
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i), 16'(16'h40 + i), 16'(i * 3), '0);
    #1;
    chk("full_in_rdy", 32'(bus.in_rdy), 32'd0);
    chk("full_count", 32'(bus.count), 32'd16);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        bus.in_vld = 1'b1; bus.in_id = 8'hEE; bus.in_spec_level = '0;
      end
      #1;
      chk("drain_vld", 32'(bus.out_vld), 32'd1);
      chk("drain_id", 32'(bus.out_id), 32'(i));
      cycle();
      bus.in_vld = 1'b0;
      if (i == 0) begin
        #1;
        chk("no_write_through_count", 32'(bus.count), 32'd15);
      end
    end
    chk("drained_count", 32'(bus.count), 32'd0);

    // Squash at level 1 leaves only the level-0 store
    do_reset();
    bus.out_rdy = 1'b1;
    push(8'd0, 16'h0100, 16'h1000, 3'd2);
    push(8'd1, 16'h0104, 16'h1001, 3'd1);
    push(8'd2, 16'h0108, 16'h1002, 3'd0);
    push(8'd3, 16'h010C, 16'h1003, 3'd2);
    bus.br_pred_vld = 1'b1; bus.br_pred_succ = 1'b0; bus.br_pred_fail_level = 3'd1;
    cycle();
    bus.br_pred_vld = 1'b0;
    ncommit = 0; cid = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.out_vld) begin ncommit++; cid = bus.out_id; end
      cycle();
    end
    chk("squash_commits", 32'(ncommit), 32'd1);
    chk("squash_id", 32'(cid), 32'd2);
    chk("squash_count", 32'(bus.count), 32'd0);

    // Two promotions 2->1->0
    do_reset();
    push(8'd7, 16'h0200, 16'h7777, 3'd2);
    bus.br_pred_vld = 1'b1; bus.br_pred_succ = 1'b1;
    bus.br_pred_succ_nxt_levels = {3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    cycle();
    #1;
    chk("promo1_out_vld", 32'(bus.out_vld), 32'd0);
    cycle();
    bus.br_pred_vld = 1'b0;
    #1;
    chk("promo2_out_vld", 32'(bus.out_vld), 32'd1);
    chk("promo2_out_id", 32'(bus.out_id), 32'd7);

    // Youngest match forwarding; same-cycle enqueue is invisible
    do_reset();
    push(8'd1, 16'h0010, 16'hAAAA, 3'd0);
    push(8'd2, 16'h0010, 16'hBBBB, 3'd0);
    bus.ld_vld = 1'b1; bus.ld_addr = 16'h0010;
    #1;
    chk("fwd_hit", 32'(bus.ld_hit), 32'd1);
    chk("fwd_data", 32'(bus.ld_data), 32'hBBBB);
    chk("fwd_id", 32'(bus.ld_id), 32'd2);
    bus.ld_addr = 16'h0020;
    bus.in_vld = 1'b1; bus.in_id = 8'd3; bus.in_addr = 16'h0020; bus.in_data = 16'hCCCC;
    #1;
    chk("miss_hit", 32'(bus.ld_hit), 32'd0);
    chk("miss_data", 32'(bus.ld_data), 32'd0);
    cycle();
    bus.in_vld = 1'b0;
    #1;
    chk("late_hit_data", 32'(bus.ld_data), 32'hCCCC);
    bus.ld_vld = 1'b0;

    // Wrap: matches in slots 15 and 1, wptr at 2
    do_reset();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 14; i++) push(8'(i), 16'h0001, 16'h0, '0);
    cycle();
    bus.out_rdy = 1'b0;
    push(8'd20, 16'h0100, 16'h1414, 3'd0);
    push(8'd21, 16'h0030, 16'h1515, 3'd1);
    push(8'd22, 16'h0200, 16'h0000, 3'd0);
    push(8'd23, 16'h0030, 16'h0101, 3'd2);
    bus.ld_vld = 1'b1; bus.ld_addr = 16'h0030;
    #1;
    chk("wrap_hit", 32'(bus.ld_hit), 32'd1);
    chk("wrap_data", 32'(bus.ld_data), 32'h0101);
    chk("wrap_id", 32'(bus.ld_id), 32'd23);
    bus.ld_vld = 1'b0;

    // Reset with pending entries
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i), 16'(16'h0300 + i), 16'(i), '0);
    rst = 1'b1; bus.out_rdy = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      bus.in_vld = ($urandom_range(0, 99) < 55);
      bus.in_id = 8'(c);
      bus.in_addr = 16'($urandom_range(0, 7) << 4);
      bus.in_data = 16'($urandom);
      bus.in_spec_level = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 4));
      bus.out_rdy = ($urandom_range(0, 99) < 70);
      bus.br_pred_vld = ($urandom_range(0, 99) < 8);
      bus.br_pred_succ = 1'($urandom_range(0, 1));
      bus.br_pred_fail_level = 3'($urandom_range(0, 4));
      nl = '0;
      for (int j = 0; j <= SPEC_DEPTH_DEF; j++) nl[j*SLB +: SLB] = SLB'($urandom_range(0, j));
      bus.br_pred_succ_nxt_levels = nl;
      bus.ld_vld = 1'($urandom_range(0, 1));
      bus.ld_addr = 16'($urandom_range(0, 8) << 4);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_fwd_buf.md
STORE_FWD_BUF -- requirements
Module: store_fwd_buf

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INST_ID_BIT, 8, instruction id width
- ADDR_BIT, 16, address width
- DATA_BIT, 16, data width
- BUF_DEPTH, 16, entries; power of two, at least 2
- SPEC_DEPTH, 4, maximum unresolved branches
- SPEC_LEVEL_BIT, clog2(SPEC_DEPTH)+1, speculation level width
- PTR_BIT, clog2(BUF_DEPTH), pointer width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: the block's one clock
- rst in 1: reset, synchronous and active-high
- in_vld in 1, in_rdy out 1: store enqueue handshake
- in_id in INST_ID_BIT, in_addr in ADDR_BIT, in_data in DATA_BIT, in_spec_level in SPEC_LEVEL_BIT: store payload
- out_vld out 1, out_rdy in 1: non-speculative commit handshake
- out_id, out_addr, out_data out (widths as in_*): head entry payload
- empty out 1: no valid entry
- count out PTR_BIT+1: occupied slots, including invalidated slots not yet skipped
- br_pred_vld in 1, br_pred_succ in 1, br_pred_fail_level in SPEC_LEVEL_BIT, br_pred_succ_nxt_levels in SPEC_LEVEL_BIT*(SPEC_DEPTH+1): branch resolution
- ld_vld in 1, ld_addr in ADDR_BIT: forwarding query
- ld_hit out 1, ld_data out DATA_BIT, ld_id out INST_ID_BIT: forwarding result

Function
REQ-003 Circular FIFO with wptr, rptr and count; in_rdy = (count < BUF_DEPTH); no write-through when full, even if draining in the same cycle.
REQ-004 Accepted store writes slot wptr (vld=1, payload, in_spec_level), then wptr advances mod BUF_DEPTH.
REQ-005 out_vld = vld[rptr] and spec_level[rptr]==0; out_* show slot rptr combinationally.
REQ-006 out_vld and out_rdy: clear vld[rptr], rptr+1, count-1.
REQ-007 Otherwise, count>0 and vld[rptr]==0: skip the slot, rptr+1, count-1.
REQ-008 Branch success: each valid entry's level becomes br_pred_succ_nxt_levels[level] in slice order.
REQ-009 Branch failure: every entry with level >= br_pred_fail_level has vld cleared; slots are reclaimed only via REQ-007.
REQ-010 Per-slot priority: enqueue, then commit, then squash/promotion; the enqueued store takes in_spec_level unmodified.
REQ-011 Count update: enqueue together with a commit or skip leaves count unchanged; enqueue alone adds 1; commit or skip alone subtracts 1.
REQ-012 Forwarding is combinational (0 latency): ld_hit=1 when ld_vld and some valid entry has addr==ld_addr.
REQ-013 On a hit, ld_data/ld_id come from the youngest match, searched from wptr-1 back to rptr with wrap; speculative entries included.
REQ-014 A store enqueued in the same cycle is not visible to the query; an entry committing in the same cycle is visible.
REQ-015 On a miss, ld_hit=0, ld_data=0, ld_id=0.
REQ-016 Age ordering between the load and buffered stores is the issuer's responsibility; the buffer forwards from all valid entries.

Reset
REQ-017 When rst is high at a clk edge: all vld=0, rptr=0, wptr=0, count=0; all other inputs ignored that cycle.
REQ-018 Outputs after reset: in_rdy=1, out_vld=0, empty=1, count=0, ld_hit=0, ld_data=0, ld_id=0.
REQ-019 Reset mid-operation discards all entries, with no commit that cycle.
REQ-020 Payload and level storage carry no reset.

Structure
REQ-021 A shared package holds the spec-level type, the default widths, and a helper that unpacks br_pred_succ_nxt_levels.
REQ-022 Sub-module sfb_match_sel: age-priority youngest-match selector over BUF_DEPTH, taking the compare vector and wptr.

Verification
REQ-023 Fill 16 stores at level 0 with out_rdy=0 -> in_rdy=0 and count=16; then out_rdy=1 -> 16 in-order commits, ids 0..15.
REQ-024 Stores at levels 2,1,0,2; branch fail at level 1 -> only entry 3 (level 0) commits, and rptr skips the squashed slots.
REQ-025 Store at level 2; branch success with nxt_levels mapping 2->1, then 1->0 -> out_vld rises the cycle after the second success.
REQ-026 Stores to 0x10 with data 0xAAAA then 0xBBBB; ld_addr=0x10 -> ld_hit=1, ld_data=0xBBBB; ld_addr=0x20 -> ld_hit=0.
REQ-027 Wrap case: wptr=2 with the matches in slots 15 and 1 -> the slot 1 data is returned.
REQ-028 Assert rst with 5 entries pending -> next cycle empty=1, count=0, out_vld=0.
